// File: rtl/instr_mem_sequencer_pkg.sv
// Shared types and defaults for the instruction memory sequencer.
package instr_mem_sequencer_pkg;

  localparam int DEF_INSTRUCTION_SIZE = 32;
  localparam int DEF_ADDR_SIZE_IM     = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_WAIT_STEP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_ONCE = 2'b00,
    MODE_LOOP = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Reserved mode code behaves as run-once.
  function automatic mode_t to_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ONCE : mode_t'(m);
  endfunction

endpackage

// File: rtl/instr_mem_sequencer_if.sv
// Load bus (write side + status) and downstream valid/ready instruction stream.
interface instr_mem_sequencer_if
  import instr_mem_sequencer_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = DEF_INSTRUCTION_SIZE
) ();

  logic                        wishbone_wr_cs_instruction_memory;
  logic                        wishbone_wr_en_instruction_memory;
  logic [INSTRUCTION_SIZE-1:0] wishbone_data_in_instruction_memory;
  logic                        wishbone_empty_instruction_memory;
  logic                        wishbone_full_instruction_memory;
  logic [INSTRUCTION_SIZE-1:0] instr_out;
  logic                        instr_valid;
  logic                        instr_ready;

  // Environment side: drives loads, consumes the instruction stream.
  modport master (
    output wishbone_wr_cs_instruction_memory,
    output wishbone_wr_en_instruction_memory,
    output wishbone_data_in_instruction_memory,
    input  wishbone_empty_instruction_memory,
    input  wishbone_full_instruction_memory,
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );

  // Sequencer side.
  modport slave (
    input  wishbone_wr_cs_instruction_memory,
    input  wishbone_wr_en_instruction_memory,
    input  wishbone_data_in_instruction_memory,
    output wishbone_empty_instruction_memory,
    output wishbone_full_instruction_memory,
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

endinterface

// File: rtl/instr_mem_sequencer_im_sram_1r1w.sv
// Synchronous 1-read 1-write array; a same-cycle read of the written address returns the old word.
module im_sram_1r1w #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_sequencer.sv
// Instruction memory loader plus program-counter sequencer streaming a [start,end] window.
module instr_mem_sequencer
  import instr_mem_sequencer_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = DEF_INSTRUCTION_SIZE,
  parameter int ADDR_SIZE_IM     = DEF_ADDR_SIZE_IM
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_mem_sequencer_if.slave    bus,
  input  logic                    clear_instruction_memory,
  input  logic                    enable_PC_IM,
  input  logic [ADDR_SIZE_IM-1:0] start_PC_IM_address,
  input  logic [ADDR_SIZE_IM-1:0] end_PC_IM_address,
  input  logic [1:0]              mode_PC_IM,
  input  logic                    step_PC_IM,
  output logic [ADDR_SIZE_IM-1:0] pc_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [ADDR_SIZE_IM:0] DEPTH_CNT = {1'b1, {ADDR_SIZE_IM{1'b0}}};

  logic [ADDR_SIZE_IM-1:0] wr_ptr;
  logic [ADDR_SIZE_IM:0]   count;
  logic [ADDR_SIZE_IM-1:0] pc;
  logic [ADDR_SIZE_IM-1:0] start_q;
  logic [ADDR_SIZE_IM-1:0] end_q;
  mode_t                   mode_q;
  state_t                  state;
  logic                    empty;
  logic                    full;
  logic                    wr_fire;
  logic                    rd_en;
  logic                    valid_q;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign wr_fire = bus.wishbone_wr_cs_instruction_memory & bus.wishbone_wr_en_instruction_memory
                 & ~full & ~clear_instruction_memory;
  assign rd_en   = (state == S_FETCH);

  assign bus.wishbone_empty_instruction_memory = empty;
  assign bus.wishbone_full_instruction_memory  = full;
  assign bus.instr_valid                       = valid_q;

  im_sram_1r1w #(
    .WIDTH (INSTRUCTION_SIZE),
    .AW    (ADDR_SIZE_IM)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.wishbone_data_in_instruction_memory),
    .rd_en   (rd_en),
    .rd_addr (pc),
    .rd_data (bus.instr_out)
  );

  // Load pointer and fill count; clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear_instruction_memory) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end
  end

  // Sequencer FSM with registered status and stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      start_q <= '0;
      end_q   <= '0;
      mode_q  <= MODE_ONCE;
      pc_out  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else if (state != S_IDLE && (!enable_PC_IM || clear_instruction_memory)) begin
      // Abort: drop the beat without an accept, keep error sticky.
      state   <= S_IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable_PC_IM && !empty && !clear_instruction_memory) begin
            state   <= S_FETCH;
            pc      <= start_PC_IM_address;
            start_q <= start_PC_IM_address;
            end_q   <= end_PC_IM_address;
            mode_q  <= to_mode(mode_PC_IM);
            error   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_FETCH: begin
          if ({1'b0, pc} >= count) begin
            state <= S_DONE;
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= S_VALID;
            valid_q <= 1'b1;
            pc_out  <= pc;
          end
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            valid_q <= 1'b0;
            if (pc == end_q) begin
              if (mode_q == MODE_LOOP) begin
                pc    <= start_q;
                state <= S_FETCH;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              pc    <= pc + 1'b1;
              state <= (mode_q == MODE_STEP) ? S_WAIT_STEP : S_FETCH;
            end
          end
        end
        S_WAIT_STEP: begin
          if (step_PC_IM) state <= S_FETCH;
        end
        S_DONE: begin
          // Held until enable drops (handled by the abort branch).
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_sequencer.sv
// Directed bench for instr_mem_sequencer: loading, run-once, loop, step, error, abort and reset.
module tb_instr_mem_sequencer;
  import instr_mem_sequencer_pkg::*;

  localparam int IW = 32;
  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic          clear_im;
  logic          enable;
  logic [AW-1:0] start_a;
  logic [AW-1:0] end_a;
  logic [1:0]    mode;
  logic          step;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          done;
  logic          error;

  int checks;
  int errors;

  instr_mem_sequencer_if #(.INSTRUCTION_SIZE(IW)) bus ();

  instr_mem_sequencer #(
    .INSTRUCTION_SIZE (IW),
    .ADDR_SIZE_IM     (AW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .bus                      (bus.slave),
    .clear_instruction_memory (clear_im),
    .enable_PC_IM             (enable),
    .start_PC_IM_address      (start_a),
    .end_PC_IM_address        (end_a),
    .mode_PC_IM               (mode),
    .step_PC_IM               (step),
    .pc_out                   (pc_out),
    .busy                     (busy),
    .done                     (done),
    .error                    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_words(input logic [IW-1:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.wishbone_wr_cs_instruction_memory   = 1'b1;
      bus.wishbone_wr_en_instruction_memory   = 1'b1;
      bus.wishbone_data_in_instruction_memory = base + i;
    end
    @(negedge clk);
    bus.wishbone_wr_cs_instruction_memory = 1'b0;
    bus.wishbone_wr_en_instruction_memory = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_im = 1'b1;
    @(negedge clk);
    clear_im = 1'b0;
  endtask

  task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [1:0] m);
    @(negedge clk);
    start_a = s;
    end_a   = e;
    mode    = m;
    enable  = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for instr_valid at a falling edge, returns edges waited.
  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.instr_valid) return;
    end
    check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_beat(input string tag, input logic [AW-1:0] epc, input logic [IW-1:0] edata,
                             input bit chk_gap);
    int unsigned n;
    wait_valid(n);
    check({tag, "_pc"}, 64'(pc_out), 64'(epc));
    check({tag, "_data"}, 64'(bus.instr_out), 64'(edata));
    if (chk_gap) check({tag, "_gap"}, 64'(n), 64'd2);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    clear_im = 1'b0;
    enable   = 1'b0;
    start_a  = '0;
    end_a    = '0;
    mode     = 2'b00;
    step     = 1'b0;
    bus.wishbone_wr_cs_instruction_memory   = 1'b0;
    bus.wishbone_wr_en_instruction_memory   = 1'b0;
    bus.wishbone_data_in_instruction_memory = '0;
    bus.instr_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_empty", 64'(bus.wishbone_empty_instruction_memory), 64'd1);
    check("rst_full", 64'(bus.wishbone_full_instruction_memory), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr_out), 64'd0);
    check("rst_pc", 64'(pc_out), 64'd0);
    check("rst_status", 64'({busy, done, error}), 64'd0);
    rst = 1'b1;

    // Run-once window 2..5 over 8 words, one beat per two cycles
    load_words(32'hA000_0000, 8);
    check("a_empty", 64'(bus.wishbone_empty_instruction_memory), 64'd0);
    start_run(7'd2, 7'd5, 2'b00);
    for (int unsigned i = 2; i <= 5; i++)
      expect_beat("a_beat", 7'(i), 32'hA000_0000 + i, 1'b1);
    @(negedge clk);
    check("a_done", 64'({done, busy, bus.instr_valid}), 64'b100);
    check("a_error", 64'(error), 64'd0);
    stop_run();
    check("a_done_clr", 64'(done), 64'd0);

    // Fill to capacity, overflow write ignored, clear
    do_clear();
    check("b_clr_empty", 64'(bus.wishbone_empty_instruction_memory), 64'd1);
    load_words(32'h0000_1000, 128);
    check("b_full", 64'(bus.wishbone_full_instruction_memory), 64'd1);
    load_words(32'hDEAD_BEEF, 1);
    check("b_full_hold", 64'(bus.wishbone_full_instruction_memory), 64'd1);
    check("b_not_empty", 64'(bus.wishbone_empty_instruction_memory), 64'd0);
    do_clear();
    check("b_empty", 64'(bus.wishbone_empty_instruction_memory), 64'd1);
    check("b_full_clr", 64'(bus.wishbone_full_instruction_memory), 64'd0);

    // Wrapping window 3..1 over 4 words: pc 4 is unloaded -> error
    load_words(32'h0000_00B0, 4);
    start_run(7'd3, 7'd1, 2'b01);
    expect_beat("c_beat", 7'd3, 32'h0000_00B3, 1'b1);
    repeat (2) @(negedge clk);
    check("c_err", 64'({error, done, busy, bus.instr_valid}), 64'b1100);
    stop_run();
    check("c_err_sticky", 64'(error), 64'd1);

    // Single-step 0..2 with ready held low
    do_clear();
    load_words(32'h0000_00C0, 4);
    bus.instr_ready = 1'b0;
    start_run(7'd0, 7'd2, 2'b10);
    expect_beat("d_beat0", 7'd0, 32'h0000_00C0, 1'b1);
    check("d_err_cleared", 64'(error), 64'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("d_hold", 64'({bus.instr_valid, bus.instr_out}), {31'd0, 1'b1, 32'h0000_00C0});
      check("d_hold_pc", 64'(pc_out), 64'd0);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("d_wait", 64'({busy, bus.instr_valid}), 64'b10);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    expect_beat("d_beat1", 7'd1, 32'h0000_00C1, 1'b0);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    expect_beat("d_beat2", 7'd2, 32'h0000_00C2, 1'b0);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("d_done", 64'({done, busy}), 64'b10);
    stop_run();

    // Loop 1..2, then abort while holding a beat
    start_run(7'd1, 7'd2, 2'b01);
    for (int unsigned k = 0; k < 2; k++) begin
      expect_beat("e_beat1", 7'd1, 32'h0000_00C1, 1'b1);
      expect_beat("e_beat2", 7'd2, 32'h0000_00C2, 1'b1);
    end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    expect_beat("e_hold", 7'd1, 32'h0000_00C1, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check("e_abort", 64'({bus.instr_valid, busy, done}), 64'd0);
    @(negedge clk);
    check("e_idle", 64'({bus.instr_valid, busy}), 64'd0);

    // Asynchronous reset while a beat is valid
    start_run(7'd0, 7'd3, 2'b00);
    expect_beat("f_beat", 7'd0, 32'h0000_00C0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("f_valid", 64'(bus.instr_valid), 64'd0);
    check("f_instr", 64'(bus.instr_out), 64'd0);
    check("f_pc", 64'(pc_out), 64'd0);
    check("f_status", 64'({busy, done, error}), 64'd0);
    check("f_empty", 64'(bus.wishbone_empty_instruction_memory), 64'd1);
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    check("f_after", 64'({bus.instr_valid, busy, done}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
